// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the RISC-V datapath. It owns the program counter,
// fetches from instruction memory with a request/ready handshake, and holds
// the fetched word in the IF/ID register for the decode stage.
//
// Decode stalls are absorbed by a one-entry skid buffer. Taken branches
// redirect the PC and flush a NOP bubble into IF/ID.
//
// Ports:
//   clk            - single clock, rising-edge
//   reset_n        - synchronous active-low reset
//   stall          - decode/hazard stall, IF/ID holds while high
//   branch_taken   - redirect request
//   branch_target  - redirect byte address (low two bits ignored)
//   imem_req       - fetch request valid
//   imem_addr      - fetch byte address (always the current PC)
//   imem_ready     - memory returns imem_rdata this cycle
//   imem_rdata     - fetched instruction
//   if_valid       - IF/ID holds a real instruction
//   if_pc          - address of the instruction in IF/ID
//   if_instr       - instruction in IF/ID
//   if_opcode      - if_instr[6:0], feeds the main controller
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  output logic [6:0]       if_opcode
);

  localparam logic [INS_W-1:0] NOP = INS_W'(32'h0000_0013);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_instr;
  logic             skid_full;

  // The target is word-aligned by dropping its two low bits.
  logic [1:0] unused_target_bits;
  assign unused_target_bits = branch_target[1:0];

  // The request is a pure decode of the state register, so it never glitches
  // on memory or stall inputs. The address is the PC itself, which only moves
  // on an accepted response, a redirect or reset.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign if_opcode = if_instr[6:0];

  // Main sequential block: reset beats redirect, redirect beats everything
  // else, then the per-state fetch/stall/skid handling.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid_full  <= 1'b0;
      skid_pc    <= RESET_PC;
      skid_instr <= NOP;
      if_valid   <= 1'b0;
      if_pc      <= RESET_PC;
      if_instr   <= NOP;
    end else if (branch_taken) begin
      // Any response arriving this cycle belongs to the wrong path and is
      // dropped, as is a buffered word.
      state     <= FETCH;
      pc        <= {branch_target[PC_W-1:2], 2'b00};
      skid_full <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= NOP;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
          end
        end

        FETCH: begin
          if (imem_ready) begin
            pc <= pc + PC_W'(4);
            if (stall) begin
              // Decode cannot take the word; park it and stop requesting
              // until the buffer drains.
              skid_full  <= 1'b1;
              skid_pc    <= pc;
              skid_instr <= imem_rdata;
              state      <= HOLD;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_instr <= imem_rdata;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
          end
        end

        HOLD: begin
          if (!stall) begin
            if_valid  <= 1'b1;
            if_pc     <= skid_pc;
            if_instr  <= skid_instr;
            skid_full <= 1'b0;
            state     <= FETCH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The buffer flag is kept for clarity of intent; HOLD already implies it.
  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. Directed steps walk through reset,
// zero-wait fetch, memory wait states, a stall into the skid buffer, a
// redirect colliding with a response, PC wrap-around and reset while a word
// is buffered, followed by a randomized phase. Expected outputs come from a
// behavioural model that tracks the PC, a queue of parked words and the
// IF/ID contents.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int          PC_W  = 9;
  localparam int          INS_W = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk;
  logic             reset_n;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ready;
  logic [INS_W-1:0] imem_rdata;
  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic [INS_W-1:0] if_instr;
  logic [6:0]       if_opcode;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PC_W-1:0]  m_pc;
  bit               m_idle;
  logic [40:0]      m_parked[$];
  logic             m_valid;
  logic [PC_W-1:0]  m_ifpc;
  logic [31:0]      m_instr;

  fetch_stage #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC('0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_opcode    (if_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model expects right now.
  task automatic checkOutput(input string tag);
    checkVal({tag, ".imem_req"},  32'(imem_req),  32'(!m_idle && m_parked.size() == 0));
    checkVal({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    checkVal({tag, ".if_valid"},  32'(if_valid),  32'(m_valid));
    checkVal({tag, ".if_pc"},     32'(if_pc),     32'(m_ifpc));
    checkVal({tag, ".if_instr"},  if_instr,       m_instr);
    checkVal({tag, ".if_opcode"}, 32'(if_opcode), 32'(m_instr[6:0]));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then
  // check the DUT one time unit after the edge.
  task automatic applyStimulus(input logic rst_n, input logic stl, input logic br,
                               input logic [PC_W-1:0] tgt, input logic rdy,
                               input logic [31:0] rdata, input string tag);
    bit got;
    logic [40:0] word;
    reset_n       = rst_n;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = rdata;

    if (!rst_n) begin
      m_pc = '0; m_idle = 1'b1; m_parked.delete();
      m_valid = 1'b0; m_ifpc = '0; m_instr = NOP;
    end else if (br) begin
      m_pc = {tgt[PC_W-1:2], 2'b00}; m_idle = 1'b0; m_parked.delete();
      m_valid = 1'b0; m_instr = NOP;
    end else begin
      got = !m_idle && m_parked.size() == 0 && rdy;
      if (!stl) begin
        if (m_parked.size() > 0) begin
          word = m_parked.pop_front();
          m_valid = 1'b1; m_ifpc = word[40:32]; m_instr = word[31:0];
        end else if (got) begin
          m_valid = 1'b1; m_ifpc = m_pc; m_instr = rdata;
        end else begin
          m_valid = 1'b0; m_instr = NOP;
        end
      end else if (got) begin
        m_parked.push_back({m_pc, rdata});
      end
      if (got) m_pc = m_pc + 9'd4;
      m_idle = 1'b0;
    end

    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    m_pc = '0; m_idle = 1'b1; m_valid = 1'b0; m_ifpc = '0; m_instr = NOP;

    $display("[TB] reset");
    applyStimulus(0, 0, 0, '0, 1, 32'h0, "reset0");
    applyStimulus(0, 0, 0, '0, 1, 32'h0, "reset1");
    checkVal("reset.imem_req", 32'(imem_req), 32'h0);
    checkVal("reset.if_opcode", 32'(if_opcode), 32'h13);

    $display("[TB] zero-wait fetch");
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "idle");
    checkVal("first_req", 32'(imem_req), 32'h1);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch0");
    checkVal("fetch0.if_pc", 32'(if_pc), 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch4");
    checkVal("fetch4.if_pc", 32'(if_pc), 32'h4);

    $display("[TB] wait states at PC 8");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 0, 32'hDEAD_BEEF, "wait");
    checkVal("wait.imem_addr", 32'(imem_addr), 32'h8);
    checkVal("wait.if_valid", 32'(if_valid), 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch8");
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch12");
    checkVal("fetch12.if_pc", 32'(if_pc), 32'hC);

    $display("[TB] stall into skid buffer");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, '0, 1, 32'(m_pc), "stall");
    checkVal("stall.if_pc", 32'(if_pc), 32'hC);
    checkVal("stall.imem_req", 32'(imem_req), 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "drain16");
    checkVal("drain16.if_instr", if_instr, 32'h10);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch20");
    checkVal("fetch20.if_instr", if_instr, 32'h14);

    $display("[TB] redirect against a response");
    applyStimulus(1, 1, 1, 9'h041, 1, 32'h18, "branch");
    checkVal("branch.imem_addr", 32'(imem_addr), 32'h40);
    checkVal("branch.if_instr", if_instr, NOP);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "target");
    checkVal("target.if_pc", 32'(if_pc), 32'h40);
    checkVal("target.if_valid", 32'(if_valid), 32'h1);

    $display("[TB] PC wrap");
    applyStimulus(1, 0, 1, 9'h1FC, 0, 32'h0, "to_top");
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch_top");
    checkVal("wrap.imem_addr", 32'(imem_addr), 32'h0);
    applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "fetch_wrap");
    checkVal("wrap.if_pc", 32'(if_pc), 32'h0);
    checkVal("wrap.if_valid", 32'(if_valid), 32'h1);

    $display("[TB] reset while holding a word");
    applyStimulus(1, 1, 0, '0, 1, 32'hCAFE_F00D, "park");
    applyStimulus(0, 1, 1, 9'h0A0, 1, 32'h0, "reset_hold");
    checkVal("reset_hold.if_instr", if_instr, NOP);
    checkVal("reset_hold.imem_addr", 32'(imem_addr), 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, '0, 1, 32'(m_pc), "after_reset");

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 64) != 0, ($urandom % 4) == 0, ($urandom % 12) == 0,
                    PC_W'($urandom), ($urandom % 3) != 0, $urandom, "random");
    end

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
